// File: rtl/dcache_sram_pkg.sv
// Shared constants, access decode and sizing helpers for the L1 data-cache SRAM and its banks.
package dcache_sram_pkg;

  localparam int BANK_WIDTH = 64;
  localparam int BANK_BYTES = BANK_WIDTH / 8;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } op_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // A request that lands on an edge with reset asserted is treated as idle.
  function automatic op_e decode_op(input logic rst, input logic req, input logic we);
    if (rst || !req) return OP_IDLE;
    return we ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/dcache_sram_bank.sv
// One 64-bit slice of the cache SRAM with byte enables and a registered read port;
// the boundary a technology macro would replace.
module dcache_sram_bank
  import dcache_sram_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int AW        = 8,
  parameter int SIM_INIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         addr,
  input  logic [BANK_WIDTH-1:0] wdata,
  input  logic [BANK_BYTES-1:0] be,
  output logic [BANK_WIDTH-1:0] rdata
);

  localparam logic INIT_BIT = (SIM_INIT != 0) ? 1'b0 : 1'bx;

  logic [BANK_WIDTH-1:0] mem [NUM_WORDS] = '{default: {BANK_WIDTH{INIT_BIT}}};
  logic                  in_range;

  assign in_range = ({1'b0, addr} < (AW + 1)'(NUM_WORDS));

  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      for (int k = 0; k < BANK_BYTES; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Read data is held between reads; out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/dcache_sram.sv
// Single-port cache SRAM of arbitrary width and depth built from 64-bit banks,
// with a per-word user sideband held in a separate register array.
module dcache_sram
  import dcache_sram_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int USER_WIDTH = 1,
  parameter  int NUM_WORDS  = 256,
  parameter  int SIM_INIT   = 0,
  localparam int AW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int BW         = ceil_div(DATA_WIDTH, 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  input  logic [BW-1:0]         be_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  localparam int   NB       = ceil_div(DATA_WIDTH, BANK_WIDTH);
  localparam int   PAD_W    = NB * BANK_WIDTH;
  localparam int   PAD_B    = NB * BANK_BYTES;
  localparam logic INIT_BIT = (SIM_INIT != 0) ? 1'b0 : 1'bx;

  op_e              op;
  logic             rd_en;
  logic             wr_en;
  logic             in_range;
  logic [PAD_W-1:0] wdata_pad;
  logic [PAD_B-1:0] be_pad;
  logic [PAD_W-1:0] rdata_pad;

  logic [USER_WIDTH-1:0] user_mem [NUM_WORDS] = '{default: {USER_WIDTH{INIT_BIT}}};

  assign op        = decode_op(rst_i, req_i, we_i);
  assign rd_en     = (op == OP_READ);
  assign wr_en     = (op == OP_WRITE);
  assign in_range  = ({1'b0, addr_i} < (AW + 1)'(NUM_WORDS));
  assign wdata_pad = PAD_W'(wdata_i);
  assign be_pad    = PAD_B'(be_i);
  assign rdata_o   = rdata_pad[DATA_WIDTH-1:0];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    dcache_sram_bank #(
      .NUM_WORDS (NUM_WORDS),
      .AW        (AW),
      .SIM_INIT  (SIM_INIT)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .rd_en (rd_en),
      .wr_en (wr_en),
      .addr  (addr_i),
      .wdata (wdata_pad[b*BANK_WIDTH +: BANK_WIDTH]),
      .be    (be_pad[b*BANK_BYTES +: BANK_BYTES]),
      .rdata (rdata_pad[b*BANK_WIDTH +: BANK_WIDTH])
    );
  end

  // The sideband is only touched by writes that enable at least one byte.
  always_ff @(posedge clk_i) begin
    if (wr_en && in_range && (|be_i)) user_mem[addr_i] <= wuser_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ruser_o <= '0;
    end else if (rd_en) begin
      ruser_o <= in_range ? user_mem[addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_dcache_sram.sv
// Directed scoreboard bench for dcache_sram: three instances cover 64-bit/6-word,
// 128-bit and 44-bit configurations.
module tb_dcache_sram;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic         a_req, a_we, a_wuser, a_ruser;
  logic [2:0]   a_addr;
  logic [63:0]  a_wdata, a_rdata;
  logic [7:0]   a_be;

  logic         b_req, b_we, b_wuser, b_ruser;
  logic [7:0]   b_addr;
  logic [127:0] b_wdata, b_rdata;
  logic [15:0]  b_be;

  logic         c_req, c_we, c_wuser, c_ruser;
  logic [3:0]   c_addr;
  logic [43:0]  c_wdata, c_rdata;
  logic [5:0]   c_be;

  dcache_sram #(.DATA_WIDTH(64), .USER_WIDTH(1), .NUM_WORDS(6), .SIM_INIT(1)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .wuser_i(a_wuser), .be_i(a_be), .rdata_o(a_rdata), .ruser_o(a_ruser)
  );

  dcache_sram #(.DATA_WIDTH(128), .USER_WIDTH(1), .NUM_WORDS(256), .SIM_INIT(0)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .wuser_i(b_wuser), .be_i(b_be), .rdata_o(b_rdata), .ruser_o(b_ruser)
  );

  dcache_sram #(.DATA_WIDTH(44), .USER_WIDTH(1), .NUM_WORDS(16), .SIM_INIT(0)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .we_i(c_we), .addr_i(c_addr),
    .wdata_i(c_wdata), .wuser_i(c_wuser), .be_i(c_be), .rdata_o(c_rdata), .ruser_o(c_ruser)
  );

  typedef struct packed {
    logic [1:0]   d;
    logic [127:0] data;
    logic         user;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic observe(input int d, output logic [127:0] data, output logic user);
    case (d)
      0:       begin data = {64'b0, a_rdata}; user = a_ruser; end
      1:       begin data = b_rdata;          user = b_ruser; end
      default: begin data = {84'b0, c_rdata}; user = c_ruser; end
    endcase
  endtask

  // One access per call: inputs change on the falling edge, the caller resumes 1 ns after the rising edge.
  task automatic apply_stimulus(input int d, input logic we, input int addr,
                                input logic [127:0] wdata, input logic [15:0] be, input logic wuser);
    @(negedge clk);
    case (d)
      0: begin
        a_req = 1'b1; a_we = we; a_addr = 3'(addr);
        a_wdata = wdata[63:0]; a_be = be[7:0]; a_wuser = wuser;
      end
      1: begin
        b_req = 1'b1; b_we = we; b_addr = 8'(addr);
        b_wdata = wdata; b_be = be; b_wuser = wuser;
      end
      default: begin
        c_req = 1'b1; c_we = we; c_addr = 4'(addr);
        c_wdata = wdata[43:0]; c_be = be[5:0]; c_wuser = wuser;
      end
    endcase
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;
    c_req = 1'b0;
  endtask

  task automatic check_output(input string tag);
    exp_t         e;
    logic [127:0] data;
    logic         user;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s: observed empty scoreboard expected a pending entry", tag);
    end else begin
      e = sb.pop_front();
      observe(int'(e.d), data, user);
      check_value({tag, "_data"}, data, e.data);
      check_value({tag, "_user"}, {127'b0, user}, {127'b0, e.user});
    end
  endtask

  task automatic do_write(input int d, input int addr, input logic [127:0] data,
                          input logic [15:0] be, input logic user);
    apply_stimulus(d, 1'b1, addr, data, be, user);
  endtask

  task automatic do_read(input int d, input int addr, input logic [127:0] exp_data,
                         input logic exp_user, input string tag);
    exp_t e;
    e.d    = 2'(d);
    e.data = exp_data;
    e.user = exp_user;
    sb.push_back(e);
    apply_stimulus(d, 1'b0, addr, '0, '0, 1'b0);
    check_output(tag);
  endtask

  initial begin
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0; a_wuser = 0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0; b_wuser = 0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0; c_wuser = 0;

    #1 rst = 1'b1;
    #2;
    check_value("reset_a_rdata", {64'b0, a_rdata}, '0);
    check_value("reset_a_ruser", {127'b0, a_ruser}, '0);
    check_value("reset_b_rdata", b_rdata, '0);
    check_value("reset_c_rdata", {84'b0, c_rdata}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Full-width write/read on the 128-bit instance
    do_write(1, 5, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 16'hFFFF, 1'b1);
    do_read(1, 5, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b1, "t1_basic");

    do_write(0, 3, 128'hFFFF_FFFF_FFFF_FFFF, 16'h00FF, 1'b0);
    do_write(0, 3, 128'h0, 16'h000F, 1'b0);
    do_read(0, 3, 128'hFFFF_FFFF_0000_0000, 1'b0, "t2_partial_be");

    // 44-bit word: the top enable covers only bits [43:40]
    do_write(2, 2, 128'h123_4567_89AB, 16'h003F, 1'b0);
    do_write(2, 2, 128'hABC_DEF0_1234, 16'h0020, 1'b0);
    do_read(2, 2, 128'hA23_4567_89AB, 1'b0, "t3_partial_byte");

    do_write(0, 4, 128'h1111, 16'h0000, 1'b1);
    do_read(0, 4, 128'h0, 1'b0, "t4_be_zero_noop");
    do_write(0, 4, 128'h2222, 16'h0001, 1'b1);
    do_read(0, 4, 128'h22, 1'b1, "t4_user_written");

    do_write(0, 2, 128'h55, 16'h00FF, 1'b0);
    do_read(0, 2, 128'h55, 1'b0, "t5_read55");
    // Idle cycle with every other control input active must not disturb anything
    @(negedge clk);
    a_we = 1'b1; a_addr = 3'd2; a_be = 8'hFF; a_wdata = 64'hDEAD_BEEF_DEAD_BEEF; a_wuser = 1'b1;
    @(posedge clk);
    #1;
    check_value("t5_hold_idle", {64'b0, a_rdata}, 128'h55);
    a_we = 1'b0; a_be = '0; a_wdata = '0; a_wuser = 1'b0;
    do_write(0, 1, 128'hDEAD, 16'h00FF, 1'b1);
    check_value("t5_hold_write", {64'b0, a_rdata}, 128'h55);
    check_value("t5_hold_write_user", {127'b0, a_ruser}, '0);

    // Mid-cycle reset, with a write presented across the reset edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("t5_async_reset", {64'b0, a_rdata}, '0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_be = 8'hFF; a_wdata = 64'hBAD; a_wuser = 1'b1;
    @(posedge clk);
    #1;
    check_value("t5_reset_hold", {64'b0, a_rdata}, '0);
    a_req = 1'b0; a_we = 1'b0; a_be = '0; a_wdata = '0; a_wuser = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_read(0, 2, 128'h55, 1'b0, "t5_after_reset");

    for (int i = 0; i < 6; i++) begin
      do_write(0, i, 128'(64'h1000 + i), 16'h00FF, i[0]);
    end
    do_write(0, 7, 128'hFFFF_FFFF_FFFF_FFFF, 16'h00FF, 1'b1);
    do_read(0, 7, 128'h0, 1'b0, "t6_read_addr7");
    do_read(0, 6, 128'h0, 1'b0, "t6_read_addr6");
    for (int i = 0; i < 6; i++) begin
      do_read(0, i, 128'(64'h1000 + i), i[0], $sformatf("t6_addr%0d", i));
    end

    check_value("scoreboard_drained", 128'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
